// File: rtl/lif_if.sv
// Bus bundle for the LIF neuron array: step control, input currents, threshold,
// probe select, and the spike, membrane-probe and spike-count outputs.
interface lif_if #(
  parameter int N = 4,
  parameter int W = 8
) ();
  localparam int VW = (N > 1) ? $clog2(N) : 1;

  logic           en;
  logic [N*W-1:0] cur_in;
  logic [W-1:0]   thresh;
  logic [VW-1:0]  vsel;
  logic [N-1:0]   spike;
  logic [W-1:0]   vmem;
  logic [15:0]    spike_cnt;

  modport master (output en, cur_in, thresh, vsel, input spike, vmem, spike_cnt);
  modport slave  (input en, cur_in, thresh, vsel, output spike, vmem, spike_cnt);
endinterface

// File: rtl/lif_neuron_array.sv
// N parallel leaky integrate-and-fire neurons with shift leak, saturating sum and refractory timer.
// Define LIF_SPIKE_COUNT_EN to build the saturating 16-bit total spike counter.
module lif_neuron_array #(
  parameter int N          = 4,
  parameter int W          = 8,
  parameter int LEAK_SHIFT = 3,
  parameter int REFRAC     = 2
) (
  input logic  clk,
  input logic  rst_n,
  lif_if.slave bus
);
  localparam int VW = (N > 1) ? $clog2(N) : 1;

  logic [W-1:0] v_q  [N];
  logic [W-1:0] v_d  [N];
  logic [7:0]   rc_q [N];
  logic [7:0]   rc_d [N];
  logic [N-1:0] spike_q, spike_d;

  always_comb begin
    logic [W:0]   sum;
    logic [W-1:0] sat;
    for (int i = 0; i < N; i++) begin
      sum        = '0;
      sat        = '0;
      v_d[i]     = v_q[i];
      rc_d[i]    = rc_q[i];
      spike_d[i] = 1'b0;
      if (bus.en) begin
        if (rc_q[i] != 8'd0) begin
          v_d[i]  = '0;
          rc_d[i] = rc_q[i] - 8'd1;
        end else begin
          // leak never exceeds v, so the subtraction cannot underflow
          sum = {1'b0, v_q[i] - (v_q[i] >> LEAK_SHIFT)} + {1'b0, bus.cur_in[i*W +: W]};
          sat = sum[W] ? {W{1'b1}} : sum[W-1:0];
          if (sat >= bus.thresh) begin
            spike_d[i] = 1'b1;
            v_d[i]     = '0;
            rc_d[i]    = 8'(REFRAC);
          end else begin
            v_d[i] = sat;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spike_q <= '0;
      for (int i = 0; i < N; i++) begin
        v_q[i]  <= '0;
        rc_q[i] <= '0;
      end
    end else begin
      spike_q <= spike_d;
      for (int i = 0; i < N; i++) begin
        v_q[i]  <= v_d[i];
        rc_q[i] <= rc_d[i];
      end
    end
  end

  always_comb begin
    bus.vmem = '0;
    for (int i = 0; i < N; i++) begin
      if (bus.vsel == VW'(i)) bus.vmem = v_q[i];
    end
  end

  assign bus.spike = spike_q;

`ifdef LIF_SPIKE_COUNT_EN
  logic [15:0] cnt_q, cnt_d, pop;
  logic [16:0] cnt_sum;

  always_comb begin
    pop = '0;
    for (int i = 0; i < N; i++) pop = pop + 16'(spike_d[i]);
    cnt_sum = {1'b0, cnt_q} + {1'b0, pop};
    cnt_d   = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign bus.spike_cnt = cnt_q;
`else
  assign bus.spike_cnt = '0;
`endif
endmodule

// File: doc/lif_neuron_array.md
# lif_neuron_array

Parametrised array of N leaky integrate-and-fire neurons updated in parallel on a shared step enable, with a shared firing threshold, shift-based leak, saturating membrane arithmetic and a per-neuron refractory period. It is the next-generation neuron core behind the TinyTapeout top-level wrapper. The wrapper maps pin groups onto the input-current bus, threshold and spike outputs, and the membrane-potential probe.

## Interface
- N, default 4: number of neurons (≥1)
- W, default 8: membrane, current and threshold width in bits (≥4)
- LEAK_SHIFT, default 3: leak is v >> LEAK_SHIFT per step (1..W-1)
- REFRAC, default 2: refractory steps after a spike (0..255)

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  step enable; one integration step per cycle it is high
- cur_in  in  N*W  unsigned input current; neuron i uses bits [i*W +: W]
- thresh  in  W  shared unsigned firing threshold, sampled every step
- spike  out  N  registered spike flags, one per neuron
- vsel  in  max(1,$clog2(N))  membrane probe select
- vmem  out  W  membrane potential of neuron vsel (combinational mux of registers; 0 if vsel ≥ N)
- spike_cnt  out  16  total spike count (see Configuration)

## Operation
- Per neuron i, state: v[i] (W bits), rc[i] (8-bit refractory counter), spike[i].
- Reset (rst_n low, asynchronous): v=0, rc=0, spike=0, spike_cnt=0. Takes effect immediately, including mid-step.
- en=0: v, rc, spike_cnt held; spike forced to 0 on the next edge.
- en=1, rc[i]≠0 (refractory): v[i]=0, cur_in ignored, rc[i] decrements by 1, spike[i]=0.
- en=1, rc[i]=0 (active):
  - sum = v − (v >> LEAK_SHIFT) + cur, computed in W+1 bits; saturate to 2^W−1 if it exceeds that value. There is no underflow because the leak is ≤ v.
  - If sum ≥ thresh: spike[i]=1, v[i]=0, rc[i]=REFRAC.
  - Otherwise: spike[i]=0, v[i]=sum.
- thresh=0: every active step fires, so the neuron fires once every REFRAC+1 steps.
- REFRAC=0: no refractory period; the neuron can fire on consecutive steps.
- Neurons are fully independent. Any subset may fire in the same step.

## Timing
- All state updates occur one clock after the en-high cycle. spike is a one-cycle pulse in the cycle following the firing step.
- Latency from cur_in or thresh change to its effect on v/spike: 1 cycle (sampled only when en=1).
- vmem reflects v one cycle after the update edge. There is no pipeline, and a new step may be issued every cycle.
- Refractory: after a spike at step k, steps k+1..k+REFRAC are refractory. Step k+REFRAC+1 integrates, starting from v=0.
- Deassertion of rst_n is not internally synchronised; the integrator guarantees its timing.

## Configuration
- LIF_SPIKE_COUNT_EN defined:
  - spike_cnt is a 16-bit register.
  - On each en=1 step, it adds the number of neurons firing in that step (popcount).
  - It saturates at 0xFFFF and does not wrap.
  - It resets to 0.
- LIF_SPIKE_COUNT_EN undefined: spike_cnt is tied to 0 and no counter or popcount logic is built.

## Test plan
- N=4, W=8, LEAK_SHIFT=3, REFRAC=2, thresh=100, cur=20 on neuron 0 with en held high:
  - v sequence is 20, 38, 54, 68, 80, 90, 99.
  - The 8th step fires: spike[0] pulses and v=0.
  - The next 2 steps keep v=0 with no spike.
  - Integration resumes at 20.
- Leak only: drive neuron 1 to v=80, then cur=0 with thresh=255 → v = 70, 62, 55, 49; spike never asserts.
- Saturation: v=200, cur=100, thresh=255 → sum 275 saturates to 255 ≥ thresh, so the neuron fires and v=0. Repeat with thresh=0: the neuron fires on every 3rd step.
- en toggling and reset:
  - en low for 5 cycles mid-integration → v, rc and spike_cnt unchanged, spike=0.
  - Assert rst_n low during a refractory period → v=0, rc=0, spike=0 immediately, with no clock edge needed.
- Simultaneous firing with LIF_SPIKE_COUNT_EN, thresh=10, all cur=255:
  - All 4 neurons fire each active step and spike_cnt increments by 4 per firing step.
  - Preload the counter near 0xFFFE → it saturates at 0xFFFF.
  - Without the macro, spike_cnt stays 0.
